flash_responder: RTL

//  Avalon-MM read-only slave that answers the flash read protocol (read/waitrequest/

---
 rtl/flash_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/flash_responder.sv
// Avalon-MM read-only slave answering flash reads from on-chip memory, standing in for the flash.
// Programmable wait states, read latency and outstanding-read limit; side port preloads words.
module flash_responder #(
  parameter int ADDR_W       = 23,
  parameter int MEM_AW       = 10,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] flsh_address,
  input  logic              flsh_read,
  input  logic [3:0]        flsh_byteenable,
  output logic              flsh_waitrequest,
  output logic [31:0]       flsh_readdata,
  output logic              flsh_readdatavalid,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [15:0]       reads_served
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              wcnt, wcnt_nxt;
  logic [3:0]              pending;
  logic                    accept;
  logic [MEM_AW-1:0]       idx;
  logic [31:0]             be_mask;
  logic [31:0]             mem [2**MEM_AW];
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];
  logic                    unused_addr_hi;

  // Upper address bits are ignored, so the memory aliases across the Avalon space.
  assign idx            = flsh_address[MEM_AW-1:0];
  assign unused_addr_hi = ^flsh_address[ADDR_W-1:MEM_AW];
  assign be_mask        = {{8{flsh_byteenable[3]}}, {8{flsh_byteenable[2]}},
                           {8{flsh_byteenable[1]}}, {8{flsh_byteenable[0]}}};

  assign flsh_readdatavalid = vld_pipe[READ_LATENCY-1];
  assign flsh_readdata      = flsh_readdatavalid ? dat_pipe[READ_LATENCY-1] : 32'h0;

  // A returning read frees its slot in the same cycle, so a full window still accepts.
  assign accept = ~reset & flsh_read & (wcnt == 4'(WAIT_CYCLES)) &
                  ((pending < 4'(MAX_PENDING)) | flsh_readdatavalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    wcnt_nxt  = 4'd0;
    case (state)
      IDLE: begin
        if (flsh_read && !accept) begin
          state_nxt = STALL;
          wcnt_nxt  = (WAIT_CYCLES > 0) ? 4'd1 : 4'd0;
        end
      end
      STALL: begin
        if (flsh_read && !accept) begin
          state_nxt = STALL;
          wcnt_nxt  = (wcnt == 4'(WAIT_CYCLES)) ? wcnt : wcnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_comb begin
    flsh_waitrequest = reset | ~accept;
  end

  // No reset on the array: preloaded samples survive a reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dat_pipe[0] <= mem[idx] & be_mask;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      dat_pipe[k] <= dat_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 4'd0;
      reads_served <= 16'd0;
    end else begin
      case ({accept, flsh_readdatavalid})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
      if (flsh_readdatavalid) begin
        reads_served <= reads_served + 16'd1;
      end
    end
  end

endmodule
